// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: command one-hots, width defaults, controller states.
// Optional macro I2C_CTRL_ADDR16_EN widens the register address to 16 bits.
package i2c_pkg;

    localparam int unsigned CMD_WIDTH_DFLT  = 6;
    localparam int unsigned DATA_WIDTH_DFLT = 8;
    localparam int unsigned DEV_ADDR_W      = 7;

`ifdef I2C_CTRL_ADDR16_EN
    localparam int unsigned REG_ADDR_W = 16;
    localparam int unsigned STATE_W    = 4;
`else
    localparam int unsigned REG_ADDR_W = 8;
    localparam int unsigned STATE_W    = 3;
`endif

    // One-hot commands understood by i2c_bit_shift; several may be OR-ed together
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_WR    = 6'b000001;
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_START = 6'b000010;
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_RD    = 6'b000100;
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_STOP  = 6'b001000;
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_ACK   = 6'b010000;
    localparam logic [CMD_WIDTH_DFLT-1:0] CMD_NACK  = 6'b100000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_WR_DEV,
`ifdef I2C_CTRL_ADDR16_EN
        ST_WR_REG_H,
`endif
        ST_WR_REG,
        ST_WR_DATA,
        ST_RD_DEV,
        ST_RD_DATA,
        ST_STOP_ERR,
        ST_DONE
    } i2c_state_e;

endpackage

// File: rtl/i2c_ctrl.sv
// Transaction-level I2C master: turns single-byte register write/read requests into
// byte commands for i2c_bit_shift. Macro I2C_CTRL_ADDR16_EN enables 16-bit register addresses.
module i2c_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CMD_WIDTH  = CMD_WIDTH_DFLT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic [DEV_ADDR_W-1:0] dev_addr,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rw_done,
    output logic                  ack_err,
    output logic                  busy,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic                  work_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  trans_done,
    input  logic                  ack_o
);

    i2c_state_e              r_state,   w_state_nxt;
    logic [CMD_WIDTH-1:0]    r_cmd,     w_cmd_nxt;
    logic [DATA_WIDTH-1:0]   r_tx,      w_tx_nxt;
    logic                    r_work_en, w_work_en_nxt;
    logic                    r_busy,    w_busy_nxt;
    logic                    r_rw_done, w_rw_done_nxt;
    logic                    r_ack_err, w_ack_err_nxt;
    logic [DATA_WIDTH-1:0]   r_rd_data, w_rd_data_nxt;
    logic [DEV_ADDR_W-1:0]   r_dev,     w_dev_nxt;
    logic [REG_ADDR_W-1:0]   r_reg,     w_reg_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata_nxt;
    logic                    r_is_rd,   w_is_rd_nxt;

    // State, registered outputs and request latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_work_en <= 1'b0;
            r_busy    <= 1'b0;
            r_rw_done <= 1'b0;
            r_ack_err <= 1'b0;
            r_rd_data <= '0;
            r_dev     <= '0;
            r_reg     <= '0;
            r_wdata   <= '0;
            r_is_rd   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_tx      <= w_tx_nxt;
            r_work_en <= w_work_en_nxt;
            r_busy    <= w_busy_nxt;
            r_rw_done <= w_rw_done_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_dev     <= w_dev_nxt;
            r_reg     <= w_reg_nxt;
            r_wdata   <= w_wdata_nxt;
            r_is_rd   <= w_is_rd_nxt;
        end
    end

    // Next state and next output values; a command is strobed on every entry into a command state
    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_tx_nxt      = r_tx;
        w_work_en_nxt = 1'b0;
        w_busy_nxt    = r_busy;
        w_rw_done_nxt = 1'b0;
        w_ack_err_nxt = r_ack_err;
        w_rd_data_nxt = r_rd_data;
        w_dev_nxt     = r_dev;
        w_reg_nxt     = r_reg;
        w_wdata_nxt   = r_wdata;
        w_is_rd_nxt   = r_is_rd;

        case (r_state)
            ST_IDLE: begin
                if (wr_req || rd_req) begin
                    w_dev_nxt     = dev_addr;
                    w_reg_nxt     = reg_addr;
                    w_wdata_nxt   = wr_data;
                    w_is_rd_nxt   = ~wr_req;
                    w_busy_nxt    = 1'b1;
                    w_ack_err_nxt = 1'b0;
                    w_state_nxt   = ST_WR_DEV;
                    w_work_en_nxt = 1'b1;
                    w_cmd_nxt     = CMD_WIDTH'(CMD_START | CMD_WR);
                    w_tx_nxt      = DATA_WIDTH'({dev_addr, 1'b0});
                end
            end
            ST_WR_DEV: begin
                if (trans_done) begin
                    w_work_en_nxt = 1'b1;
                    if (ack_o) begin
                        w_state_nxt = ST_STOP_ERR;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_STOP);
                        w_tx_nxt    = '0;
                    end else begin
                        w_cmd_nxt   = CMD_WIDTH'(CMD_WR);
`ifdef I2C_CTRL_ADDR16_EN
                        w_state_nxt = ST_WR_REG_H;
                        w_tx_nxt    = DATA_WIDTH'(r_reg[15:8]);
`else
                        w_state_nxt = ST_WR_REG;
                        w_tx_nxt    = DATA_WIDTH'(r_reg[7:0]);
`endif
                    end
                end
            end
`ifdef I2C_CTRL_ADDR16_EN
            ST_WR_REG_H: begin
                if (trans_done) begin
                    w_work_en_nxt = 1'b1;
                    if (ack_o) begin
                        w_state_nxt = ST_STOP_ERR;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_STOP);
                        w_tx_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_WR_REG;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_WR);
                        w_tx_nxt    = DATA_WIDTH'(r_reg[7:0]);
                    end
                end
            end
`endif
            ST_WR_REG: begin
                if (trans_done) begin
                    w_work_en_nxt = 1'b1;
                    if (ack_o) begin
                        w_state_nxt = ST_STOP_ERR;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_STOP);
                        w_tx_nxt    = '0;
                    end else if (r_is_rd) begin
                        w_state_nxt = ST_RD_DEV;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_START | CMD_WR);
                        w_tx_nxt    = DATA_WIDTH'({r_dev, 1'b1});
                    end else begin
                        w_state_nxt = ST_WR_DATA;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_WR | CMD_STOP);
                        w_tx_nxt    = r_wdata;
                    end
                end
            end
            ST_WR_DATA: begin
                // STOP already travels with the data byte, so a NACK here needs no extra command
                if (trans_done) begin
                    w_state_nxt   = ST_DONE;
                    w_rw_done_nxt = 1'b1;
                    w_ack_err_nxt = ack_o;
                end
            end
            ST_RD_DEV: begin
                if (trans_done) begin
                    w_work_en_nxt = 1'b1;
                    if (ack_o) begin
                        w_state_nxt = ST_STOP_ERR;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_STOP);
                        w_tx_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_RD_DATA;
                        w_cmd_nxt   = CMD_WIDTH'(CMD_RD | CMD_NACK | CMD_STOP);
                        w_tx_nxt    = '0;
                    end
                end
            end
            ST_RD_DATA: begin
                if (trans_done) begin
                    w_state_nxt   = ST_DONE;
                    w_rw_done_nxt = 1'b1;
                    w_ack_err_nxt = 1'b0;
                    w_rd_data_nxt = rx_data;
                end
            end
            ST_STOP_ERR: begin
                if (trans_done) begin
                    w_state_nxt   = ST_DONE;
                    w_rw_done_nxt = 1'b1;
                    w_ack_err_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_cmd_nxt   = '0;
                w_tx_nxt    = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_data = r_rd_data;
    assign rw_done = r_rw_done;
    assign ack_err = r_ack_err;
    assign busy    = r_busy;
    assign cmd     = r_cmd;
    assign work_en = r_work_en;
    assign tx_data = r_tx;

endmodule

// File: doc/i2c_ctrl.md
# i2c_ctrl

Transaction-level I2C master controller that sits directly upstream of `i2c_bit_shift`. It accepts single-byte register write and read requests and breaks each into the byte-level command sequence the bit shifter executes. It drives `cmd`, `work_en` and `tx_data`, and consumes `rx_data`, `trans_done` and `ack_o`. Target devices are 24LC-series EEPROMs and similar register-mapped I2C slaves.

## Interface
- CMD_WIDTH, 6, width of the one-hot command bus to the bit shifter
- DATA_WIDTH, 8, byte width
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  single-cycle pulse; starts a register write
- rd_req  in  1  single-cycle pulse; starts a register read
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8 (16 with `I2C_CTRL_ADDR16_EN`)  register/memory address
- wr_data  in  8  byte to write
- rd_data  out  8  last byte read; reset 0
- rw_done  out  1  one-cycle pulse at transaction end; reset 0
- ack_err  out  1  valid with `rw_done`; 1 means the slave NACKed; reset 0
- busy  out  1  high from request acceptance until `rw_done`; reset 0
- cmd  out  6  one-hot OR of WR=000001, START=000010, RD=000100, STOP=001000, ACK=010000, NACK=100000; reset 0
- work_en  out  1  one-cycle command strobe to the bit shifter; reset 0
- tx_data  out  8  byte for the current WR command; reset 0
- rx_data  in  8  byte returned by the bit shifter after RD
- trans_done  in  1  one-cycle pulse; the current command has finished
- ack_o  in  1  slave acknowledge sampled after WR; 0=ACK, 1=NACK

## Operation
- States: IDLE, WR_DEV, WR_REG_H (ADDR16 only), WR_REG, WR_DATA, RD_DEV, RD_DATA, STOP_ERR, DONE.
- IDLE: latches dev_addr, reg_addr and wr_data on a request. If wr_req and rd_req are asserted in the same cycle, the write wins and rd_req is dropped. Requests received while busy=1 are ignored.
- Write sequence:
  - WR_DEV: START|WR, tx={dev,0}
  - WR_REG: WR, tx=reg_addr
  - WR_DATA: WR|STOP, tx=wr_data
  - then DONE
- Read sequence:
  - WR_DEV: START|WR, tx={dev,0}
  - WR_REG: WR, tx=reg_addr
  - RD_DEV: START|WR, tx={dev,1}
  - RD_DATA: RD|NACK|STOP
  - then DONE, with rd_data taken from rx_data
- On entering each command state, drive work_en=1 for exactly one cycle. Hold cmd and tx_data stable until trans_done, then advance.
- NACK handling: if ack_o=1 at trans_done of any WR-carrying state that has no STOP, go to STOP_ERR and issue a lone STOP command. After its trans_done, go to DONE with ack_err=1.
- A NACK on WR_DATA, which already carries STOP, goes straight to DONE with ack_err=1.
- rd_data is updated only on a successful read; otherwise it holds its previous value.
- DONE: pulses rw_done for one cycle, clears busy, and returns to IDLE. ack_err holds until the next request is accepted.
- trans_done outside a waiting state is ignored.

## Timing
- Request in cycle N: busy=1 and work_en=1 in cycle N+1, with cmd/tx_data valid in the same cycle.
- trans_done in cycle M: the next work_en fires at M+1. Command-to-command overhead is one cycle.
- The last trans_done at M gives rw_done at M+1 and busy=0 at M+2. A new request is accepted from M+2.
- Reset mid-transaction returns to IDLE with all outputs at their reset values. The bit shifter shares rst_n, so the bus is not explicitly stopped.

## Configuration
- `I2C_CTRL_ADDR16_EN` defined:
  - reg_addr is 16 bits.
  - WR_REG_H (WR, tx=reg_addr[15:8]) is inserted between WR_DEV and WR_REG.
  - WR_REG sends reg_addr[7:0].
  - A NACK in WR_REG_H routes to STOP_ERR.
- Undefined: reg_addr is 8 bits, WR_REG_H does not exist, and the state encoding omits it.

## Structure
- Package `i2c_pkg` holds:
  - the command one-hot constants WR/START/RD/STOP/ACK/NACK
  - CMD_WIDTH and DATA_WIDTH defaults
  - the state enumeration
- `i2c_bit_shift` uses the same package.
- No sub-module: this is a single FSM plus request latches. The parent `i2c_top` instantiates `i2c_ctrl` and `i2c_bit_shift` side by side.

## Test plan
- Write dev=0x50, reg=0x12, data=0xA5, behavioural shifter always ACKs:
  - commands 000011/tx 0xA0, 000001/tx 0x12, 001001/tx 0xA5
  - rw_done=1, ack_err=0
- Read dev=0x50, reg=0x34, shifter returns rx_data=0x5C:
  - commands 000011/0xA0, 000001/0x34, 000011/0xA1, 101100
  - rd_data=0x5C, ack_err=0
- NACK on the device byte (ack_o=1 after the first trans_done):
  - next cmd=001000 (STOP only)
  - rw_done with ack_err=1; rd_data unchanged
- wr_req and rd_req asserted together; wr_req pulsed again while busy:
  - exactly one write transaction runs
  - exactly one rw_done
- rst_n asserted while waiting in RD_DATA:
  - all outputs 0 next cycle
  - a fresh write after release completes normally
- With `I2C_CTRL_ADDR16_EN`, write reg=0x01F0:
  - tx sequence 0xA0, 0x01, 0xF0, data
  - a NACK on the 0x01 byte gives a STOP-only command and ack_err=1
